pipe_stage_skid: RTL

Parametrised pipeline stage register: the next generation of the per-bit-dff stage latches between processor stages. It carries one payload word and one vector of decode-control flags. It replaces the bare write_en with a valid/ready handshake backed by a 2-entry skid buffer, adds a synchronous flush for branch/halt squash, and zeroes control on bubbles. Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB with per-site widths.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/pipe_reg_bank.sv | 24 ++
 rtl/pipe_stage_skid.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage registers.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } skid_state_t;

   localparam int unsigned PIPE_DATA_W = 64;
   localparam int unsigned PIPE_CTRL_W = 10;

   // Bit positions inside the decode-control flag vector.
   localparam int unsigned CTRL_COMPUTE   = 0;
   localparam int unsigned CTRL_LW        = 1;
   localparam int unsigned CTRL_SW        = 2;
   localparam int unsigned CTRL_B         = 3;
   localparam int unsigned CTRL_J         = 4;
   localparam int unsigned CTRL_IMM       = 5;
   localparam int unsigned CTRL_RF_WE     = 6;
   localparam int unsigned CTRL_MEM_TO_RF = 7;
   localparam int unsigned CTRL_ALU_SUB   = 8;
   localparam int unsigned CTRL_HLT       = 9;

   function automatic logic [1:0] occ_of(input skid_state_t s);
      logic [1:0] occ;
      occ = 2'd0;
      unique case (s)
         EMPTY:   occ = 2'd0;
         ONE:     occ = 2'd1;
         FULL:    occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/pipe_reg_bank.sv
// Load-enabled register vector with asynchronous active-low clear.
module pipe_reg_bank #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, flush and bubble ctrl gating.
// Optional stall counter output is enabled by defining PIPE_STALL_CNT_EN.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = PIPE_DATA_W,
   parameter int unsigned CTRL_W = PIPE_CTRL_W,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
`ifdef PIPE_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt
`endif
);

   localparam int unsigned ENT_W = DATA_W + CTRL_W;

   skid_state_t      r_state;
   skid_state_t      w_state_nxt;
   logic             w_in_xfer;
   logic             w_out_xfer;
   logic             w_main_ld;
   logic             w_skid_ld;
   logic [ENT_W-1:0] w_in_ent;
   logic [ENT_W-1:0] w_main_d;
   logic [ENT_W-1:0] w_main_q;
   logic [ENT_W-1:0] w_skid_q;

   // Handshake flags come straight from the state register; no out_ready path to in_ready.
   assign in_ready   = (r_state != FULL);
   assign out_valid  = (r_state != EMPTY);
   assign w_in_xfer  = in_valid && in_ready;
   assign w_out_xfer = out_valid && out_ready;
   assign w_in_ent   = {in_ctrl, in_data};

   always_comb begin
      w_state_nxt = r_state;
      w_main_ld   = 1'b0;
      w_skid_ld   = 1'b0;
      unique case (r_state)
         EMPTY: begin
            if (w_in_xfer) begin
               w_main_ld   = 1'b1;
               w_state_nxt = ONE;
            end
         end
         ONE: begin
            if (w_in_xfer && w_out_xfer) begin
               w_main_ld = 1'b1;
            end else if (w_in_xfer) begin
               w_skid_ld   = 1'b1;
               w_state_nxt = FULL;
            end else if (w_out_xfer) begin
               w_state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (w_out_xfer) begin
               w_main_ld   = 1'b1;
               w_state_nxt = ONE;
            end
         end
         default: w_state_nxt = EMPTY;
      endcase
      // Squash wins over any transfer; data registers keep their contents.
      if (flush) begin
         w_state_nxt = EMPTY;
         w_main_ld   = 1'b0;
         w_skid_ld   = 1'b0;
      end
   end

   assign w_main_d = (r_state == FULL) ? w_skid_q : w_in_ent;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   pipe_reg_bank #(
      .WIDTH(ENT_W)
   ) u_main (
      .i_clk  (clk),
      .i_rst_n(rst),
      .i_load (w_main_ld),
      .i_d    (w_main_d),
      .o_q    (w_main_q)
   );

   pipe_reg_bank #(
      .WIDTH(ENT_W)
   ) u_skid (
      .i_clk  (clk),
      .i_rst_n(rst),
      .i_load (w_skid_ld),
      .i_d    (w_in_ent),
      .o_q    (w_skid_q)
   );

   assign out_data  = w_main_q[DATA_W-1:0];
   assign out_ctrl  = w_main_q[ENT_W-1:DATA_W] & {CTRL_W{out_valid}};
   assign occupancy = occ_of(r_state);

`ifdef PIPE_STALL_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
      end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   logic w_unused_cnt_w;
   assign w_unused_cnt_w = ^CNT_W;
`endif

endmodule
